// File: rtl/grom_pkg.sv
// Shared constants for the grom system: default bus widths and the
// read-return state encodings used by ram_arbiter.
package grom_pkg;

   localparam int ADDR_W_DEF = 12;
   localparam int DATA_W_DEF = 8;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RD_A  = 2'd1;
   localparam logic [1:0] ST_RD_B  = 2'd2;
   localparam logic [1:0] ST_RD_IO = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE  = ST_IDLE,
      S_RD_A  = ST_RD_A,
      S_RD_B  = ST_RD_B,
      S_RD_IO = ST_RD_IO
   } rd_state_t;

endpackage

// File: rtl/ram_arbiter.sv
// Shares the single-port RAM between the CPU (port A) and a secondary master
// (port B), and captures CPU I/O writes into a registered output port.
// Build option ARB_ROUND_ROBIN_EN: round-robin RAM arbitration instead of
// CPU priority with a starvation limit.
//
// state   | meaning
// --------+---------------------------------------------------
// S_IDLE  | no read issued last cycle, rdata = 0
// S_RD_A  | CPU RAM read issued last cycle, return ram_rdata
// S_RD_B  | port B RAM read issued last cycle, return ram_rdata
// S_RD_IO | CPU I/O read issued last cycle, return io_data
module ram_arbiter
   import grom_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              a_req,
   input  logic              a_we,
   input  logic              a_ioreq,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_gnt,
   output logic              a_stall,
   output logic              a_rvalid,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_gnt,
   output logic              b_rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [DATA_W-1:0] io_data,
   output logic              io_strobe
);

   rd_state_t         state;
   rd_state_t         state_nxt;
   logic [ADDR_W-1:0] addr_hold;
   logic              io_wr;
   logic              io_rd;
   logic              a_mem;
   logic              a_slot;
   logic              b_win;

`ifdef ARB_ROUND_ROBIN_EN
   logic              last_owner;   // 1 = port B won the last contended slot
`else
   logic [3:0]        wait_cnt;
`endif

   // An I/O read also claims the slot: its return shares rdata with RAM reads.
   always_comb begin
      io_wr  = a_req & a_ioreq & a_we;
      io_rd  = a_req & a_ioreq & ~a_we;
      a_mem  = a_req & ~a_ioreq;
      a_slot = a_mem | io_rd;
`ifdef ARB_ROUND_ROBIN_EN
      b_win  = b_req & (~a_slot | ~last_owner);
`else
      b_win  = b_req & (~a_slot | (wait_cnt == 4'(STARVE_MAX)));
`endif
      b_gnt   = b_win & ~reset;
      a_gnt   = a_req & (io_wr | ~b_win) & ~reset;
      a_stall = a_req & ~a_gnt;
   end

   always_comb begin
      ram_addr  = addr_hold;
      ram_wdata = '0;
      ram_we    = 1'b0;
      if (b_gnt) begin
         ram_addr  = b_addr;
         ram_wdata = b_wdata;
         ram_we    = b_we;
      end else if (a_gnt & a_mem) begin
         ram_addr  = a_addr;
         ram_wdata = a_wdata;
         ram_we    = a_we;
      end
   end

   always_comb begin
      state_nxt = S_IDLE;
      if (b_gnt & ~b_we)
         state_nxt = S_RD_B;
      else if (a_gnt & a_mem & ~a_we)
         state_nxt = S_RD_A;
      else if (a_gnt & io_rd)
         state_nxt = S_RD_IO;
   end

   always_comb begin
      case (state)
         S_RD_A, S_RD_B: rdata = ram_rdata;
         S_RD_IO:        rdata = io_data;
         default:        rdata = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         a_rvalid  <= 1'b0;
         b_rvalid  <= 1'b0;
         addr_hold <= '0;
         io_data   <= '0;
         io_strobe <= 1'b0;
      end else begin
         state     <= state_nxt;
         a_rvalid  <= (state_nxt == S_RD_A) | (state_nxt == S_RD_IO);
         b_rvalid  <= (state_nxt == S_RD_B);
         addr_hold <= ram_addr;
         io_strobe <= io_wr & a_gnt;
         if (io_wr & a_gnt)
            io_data <= a_wdata;
      end
   end

`ifdef ARB_ROUND_ROBIN_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         last_owner <= 1'b1;
      else if (b_gnt)
         last_owner <= 1'b1;
      else if (a_gnt & a_slot)
         last_owner <= 1'b0;
   end
`else
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         wait_cnt <= 4'd0;
      else if (~b_req | b_gnt)
         wait_cnt <= 4'd0;
      else if (wait_cnt != 4'(STARVE_MAX))
         wait_cnt <= wait_cnt + 4'd1;
   end
`endif

endmodule
